ofifo_collect: RTL and testbench
================================

// Module: ofifo_collect
// PURPOSE
//  Output-side collector at the bottom of the systolic array (MAC tile rows -> SRAM).
//  Columns emit psums skewed one cycle apart (col 0 first). Each column gets a private
//  circular buffer written on its own valid strobe; a row is released only when every
//  column holds data, so each read returns one aligned row of col psums.
// PARAMETERS
//  col    8    number of array columns / independent lanes
//  bw     16   psum width per column
//  depth  64   entries per column buffer, power of two; pointer width = log2(depth)
// PORTS
//  clk         in   1        single clock, all state on posedge
//  reset       in   1        asynchronous, active-high; clears all state immediately
//  in          in   col*bw   packed [col-1:0][bw-1:0] psums from array bottom row
//  wr          in   col      per-column write strobe (array valid), independent per lane
//  rd          in   1        pop one aligned row from all columns
//  out         out  col*bw   registered aligned row, [col-1:0][bw-1:0]
//  o_valid     out  1        every column non-empty: a row is available to rd
//  o_full      out  1        ANY column full: upstream must stall the array
//  o_overflow  out  1        sticky: a write reached a full column
//  o_underflow out  1        sticky: rd asserted while o_valid low
// BEHAVIOUR
//  - Reset (async assert): wr/rd pointers=0, counts=0, out=0, o_valid=0, o_full=0,
//    o_overflow=0, o_underflow=0. Storage not cleared (unreachable). Reset mid-traffic
//    discards all buffered entries. Deassertion synchronous to clk.
//  - Per column i: count_i in 0..depth (log2(depth)+1 bits). empty_i=(count_i==0),
//    full_i=(count_i==depth). Pointers wrap modulo depth (depth-1 -> 0).
//  - Write: wr[i] && !full_i stores in[i] at wptr_i, wptr_i++, count_i++.
//    wr[i] && full_i: data dropped, no pointer change, o_overflow<=1.
//  - o_valid = &(~empty), combinational from counts. o_full = |full.
//  - Read accepted when rd && o_valid: every column: out[i]<=mem_i[rptr_i], rptr_i++,
//    count_i--. out valid the cycle after rd (1-cycle latency); holds otherwise.
//    rd && !o_valid: no state change, out holds, o_underflow<=1.
//  - Same-cycle wr[i] and accepted rd on column i: both take effect, count_i unchanged;
//    legal even when full_i (rd frees slot same cycle -> write accepted, no overflow)
//    and when count_i==1 (read returns old head, new entry stored).
//  - Write never visible to rd in the same cycle it arrives (empty->valid next cycle).
//  - Sticky flags cleared only by reset. No state machine beyond per-lane counters.
// TESTING
//  1 Reset then idle: all outputs 0, o_valid=0, o_full=0 for 10 cycles.
//  2 Skewed write: wr=8'b00000001,00000011,...,8'hFF over 8 cycles, in[i]=16*row+i;
//    o_valid rises one cycle after col 7 writes; rd -> out[i]=i next cycle.
//  3 Fill: 64 rows into all columns -> o_full=1; 65th write on col 3 -> o_overflow=1,
//    after 64 reads col 3 returns rows 0..63 only, no corruption.
//  4 rd with col 5 empty (others 4 deep) -> out unchanged, o_underflow=1, counts held.
//  5 Full buffer, rd and wr=8'hFF same cycle -> o_overflow stays 0, counts stay 64;
//    100 rows streamed with wrap-around read back in order.
//  6 Async reset pulse mid-stream (between clk edges) -> outputs 0 immediately,
//    o_valid=0; post-reset traffic read starts at first new row.

Source files
------------

// File: rtl/ofifo_collect.sv
// ofifo_collect: per-column circular buffers that release only fully populated, aligned rows
module ofifo_collect #(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int depth = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col-1:0][bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col-1:0][bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_underflow
);
    localparam int pw = $clog2(depth);

    logic [bw-1:0]            mem [col][depth];
    logic [col-1:0][pw-1:0]   wptr, rptr;
    logic [col-1:0][pw:0]     count;
    logic [col-1:0]           empty, full, wr_ok;
    logic                     rd_ok;

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign rd_ok   = rd && o_valid;

    // A read in the same cycle frees a slot, so a full lane may still accept
    for (genvar g = 0; g < col; g++) begin : lane
        assign empty[g] = count[g] == '0;
        assign full[g]  = count[g] == (pw+1)'(depth);
        assign wr_ok[g] = wr[g] && (!full[g] || rd_ok);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++)
            if (wr_ok[i]) mem[i][wptr[i]] <= in[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            out         <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                wptr[i]  <= wptr[i] + pw'(wr_ok[i]);
                rptr[i]  <= rptr[i] + pw'(rd_ok);
                count[i] <= count[i] + (pw+1)'(wr_ok[i]) - (pw+1)'(rd_ok);
                if (rd_ok) out[i] <= mem[i][rptr[i]];
            end
            o_overflow  <= o_overflow | (|(wr & ~wr_ok));
            o_underflow <= o_underflow | (rd && !o_valid);
        end
    end
endmodule

// File: tb/tb_ofifo_collect.sv
// tb_ofifo_collect: randomized scenarios checked against a per-column queue model
module tb_ofifo_collect;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0][15:0]  din = '0;
    logic [7:0]        wr = '0;
    logic              rd = 1'b0;
    logic [7:0][15:0]  out;
    logic              o_valid, o_full, o_overflow, o_underflow;

    logic [15:0]       q[8][$];
    logic [7:0][15:0]  eo;
    logic              eovf, eunf;
    int                vectors = 0;
    int                miscompares = 0;

    ofifo_collect dut (
        .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic ev();
        for (int i = 0; i < 8; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic ef();
        for (int i = 0; i < 8; i++) if (q[i].size() == 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) q[i].delete();
        eo = '0;
        eovf = 1'b0;
        eunf = 1'b0;
    endtask

    // Drive one cycle; the model applies the same edge using whole-row queue semantics
    task automatic cyc(input logic [7:0] w, input logic r, input logic [127:0] d);
        logic v;
        wr = w;
        rd = r;
        din = d;
        @(posedge clk);
        v = ev();
        if (r && v) for (int i = 0; i < 8; i++) eo[i] = q[i].pop_front();
        if (r && !v) eunf = 1'b1;
        for (int i = 0; i < 8; i++)
            if (w[i]) begin
                if (q[i].size() < 64) q[i].push_back(d[i*16 +: 16]);
                else eovf = 1'b1;
            end
        #1;
    endtask

    task automatic do_reset();
        wr = '0;
        rd = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            cyc('0, 1'b0, rnd());
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== 132'h0) begin
                miscompares++;
                $display("FAIL reset_idle: got %h exp 0", {out, o_valid, o_full, o_overflow, o_underflow});
            end
        end
    endtask

    task automatic test_skew();
        int cnt[8];
        logic [7:0] w;
        logic [127:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int r = 0; r < 8; r++) begin
            w = 8'((16'h1 << (r + 1)) - 16'h1);
            d = rnd();
            for (int i = 0; i < 8; i++)
                if (w[i]) begin
                    d[i*16 +: 16] = 16'(16 * cnt[i] + i);
                    cnt[i]++;
                end
            cyc(w, 1'b0, d);
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== {eo, ev(), ef(), eovf, eunf}
                || o_valid !== (r == 7)) begin
                miscompares++;
                $display("FAIL skew_write r=%0d: got %h exp %h", r,
                         {out, o_valid, o_full, o_overflow, o_underflow}, {eo, ev(), ef(), eovf, eunf});
            end
        end
        cyc('0, 1'b1, rnd());
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (out[i] !== 16'(i)) begin
                miscompares++;
                $display("FAIL skew_read col%0d: got %h exp %h", i, out[i], 16'(i));
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 64; c++) cyc(8'hFF, 1'b0, rnd());
        vectors++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got full=%b ovf=%b exp full=1 ovf=0", o_full, o_overflow);
        end
        cyc(8'h08, 1'b0, rnd());
        vectors++;
        if (o_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_overflow: got %b exp 1", o_overflow);
        end
        for (int c = 0; c < 64; c++) begin
            cyc('0, 1'b1, rnd());
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== {eo, ev(), ef(), eovf, eunf}) begin
                miscompares++;
                $display("FAIL fill_drain c=%0d: got %h exp %h", c,
                         {out, o_valid, o_full, o_overflow, o_underflow}, {eo, ev(), ef(), eovf, eunf});
            end
        end
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_empty: got o_valid=%b exp 0", o_valid);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int c = 0; c < 4; c++) cyc(8'hDF, 1'b0, rnd());
        cyc('0, 1'b1, rnd());
        vectors++;
        if (o_underflow !== 1'b1 || out !== 128'h0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow: got unf=%b out=%h valid=%b exp unf=1 out=0 valid=0",
                     o_underflow, out, o_valid);
        end
        for (int c = 0; c < 4; c++) cyc(8'h20, 1'b0, rnd());
        for (int c = 0; c < 5; c++) begin
            cyc('0, c < 4, rnd());
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== {eo, ev(), ef(), eovf, eunf}) begin
                miscompares++;
                $display("FAIL underflow_held c=%0d: got %h exp %h", c,
                         {out, o_valid, o_full, o_overflow, o_underflow}, {eo, ev(), ef(), eovf, eunf});
            end
        end
    endtask

    task automatic test_full_stream();
        do_reset();
        for (int c = 0; c < 64; c++) cyc(8'hFF, 1'b0, rnd());
        for (int c = 0; c < 164; c++) begin
            cyc(c < 100 ? 8'hFF : 8'h00, 1'b1, rnd());
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== {eo, ev(), ef(), eovf, eunf}
                || o_overflow !== 1'b0 || (c < 100 && o_full !== 1'b1)) begin
                miscompares++;
                $display("FAIL full_stream c=%0d: got %h exp %h", c,
                         {out, o_valid, o_full, o_overflow, o_underflow}, {eo, ev(), ef(), eovf, eunf});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 12; c++) cyc(8'((c % 3 == 2) ? 8'h00 : $urandom()), c > 6, rnd());
        #3;
        wr = '0;
        rd = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if ({out, o_valid, o_full, o_overflow, o_underflow} !== 132'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h exp 0", {out, o_valid, o_full, o_overflow, o_underflow});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            cyc(c < 5 ? 8'hFF : 8'h00, c >= 5, rnd());
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== {eo, ev(), ef(), eovf, eunf}) begin
                miscompares++;
                $display("FAIL post_reset c=%0d: got %h exp %h", c,
                         {out, o_valid, o_full, o_overflow, o_underflow}, {eo, ev(), ef(), eovf, eunf});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            w = (c % 200 < 100) ? 8'($urandom() | $urandom()) : 8'($urandom() & $urandom());
            cyc(w, $urandom_range(0, 3) == 0 || (c % 200 >= 100 && $urandom_range(0, 1) == 1), rnd());
            vectors++;
            if ({out, o_valid, o_full, o_overflow, o_underflow} !== {eo, ev(), ef(), eovf, eunf}) begin
                miscompares++;
                $display("FAIL random c=%0d: got %h exp %h", c,
                         {out, o_valid, o_full, o_overflow, o_underflow}, {eo, ev(), ef(), eovf, eunf});
            end
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_fill();
        test_underflow();
        test_full_stream();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
